// File: rtl/sqrt_arbiter_if.sv
//------------------------------------------------------------------------------
// sqrt_arbiter_if
// Bundles the client-side request bus and the datapath-side handshake of the
// sqrt arbiter.
//   req    : per-requester request level          (client -> arbiter)
//   x      : packed operands, requester i at [i*Width +: Width]
//   done   : one-cycle completion pulse, one-hot   (arbiter -> client)
//   y      : registered result
//   err    : one-cycle timeout-abort pulse
//   busy   : arbiter is serving a request
//   sq_req : request level to the sqrt datapath   (arbiter -> datapath)
//   sq_x   : operand to the sqrt datapath
//   sq_fin : asynchronous finish pulse             (datapath -> arbiter)
//   sq_y   : datapath result
// The slave modport is the arbiter's view; master is the environment's view.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface sqrt_arbiter_if #(
   parameter int Width = 32,
   parameter int N     = 4
);
   logic [N-1:0]       req;
   logic [N*Width-1:0] x;
   logic [N-1:0]       done;
   logic [Width-1:0]   y;
   logic               err;
   logic               busy;
   logic               sq_req;
   logic [Width-1:0]   sq_x;
   logic               sq_fin;
   logic [Width-1:0]   sq_y;

   modport master (
      output req, x, sq_fin, sq_y,
      input  done, y, err, busy, sq_req, sq_x
   );

   modport slave (
      input  req, x, sq_fin, sq_y,
      output done, y, err, busy, sq_req, sq_x
   );
endinterface

// File: rtl/sqrt_arbiter.sv
//------------------------------------------------------------------------------
// sqrt_arbiter
// Round-robin arbiter/sequencer sharing one self-timed sqrt datapath among N
// requesters. Grants one requester at a time, drives the datapath operand and
// request level, captures the asynchronous finish pulse through a toggle
// synchronizer, returns the result with a one-cycle done pulse, and aborts with
// an err pulse if the datapath does not answer within TimeoutCycles.
// Ports:
//   clk   : system clock, all state changes on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : sqrt_arbiter_if.slave (client request bus + datapath handshake)
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module sqrt_arbiter #(
   parameter int Width         = 32,
   parameter int N             = 4,
   parameter int TimeoutCycles = 255
) (
   input  logic          clk,
   input  logic          rst_n,
   sqrt_arbiter_if.slave bus
);
   localparam int PW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = $clog2(TimeoutCycles);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DRAIN} state_t;

   state_t           r_state, w_state_nxt;
   logic [PW-1:0]    r_ptr, w_ptr_nxt, w_gnt;
   logic [Width-1:0] r_sq_x, w_sq_x_nxt;
   logic             r_sq_req, w_sq_req_nxt;
   logic [Width-1:0] r_y, w_y_nxt;
   logic [N-1:0]     r_done, w_done_nxt;
   logic             r_err, w_err_nxt;
   logic [CW-1:0]    r_cnt, w_cnt_nxt;
   logic             r_drn, w_drn_nxt;
   logic             r_tog, r_s1, r_s2, r_s3;
   logic             w_ev;

   // First requesting index after the last grant, wrapping around.
   function automatic logic [PW-1:0] rr_pick(input logic [N-1:0] rq,
                                             input logic [PW-1:0] last);
      logic [PW-1:0] g;
      logic [PW-1:0] i_idx;
      logic          found;
      int            idx;
      g     = last;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
         idx   = (int'(last) + k) % N;
         i_idx = idx[PW-1:0];
         if (!found && rq[i_idx]) begin
            g     = i_idx;
            found = 1'b1;
         end
      end
      return g;
   endfunction

   // The datapath fin pulse may be shorter than a clock period, so it flips a
   // toggle flop that is then synchronized; any change of s2 is one event.
   always_ff @(posedge bus.sq_fin or negedge rst_n) begin
      if (!rst_n) r_tog <= 1'b0;
      else        r_tog <= ~r_tog;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= r_tog;
         r_s2 <= r_s1;
         r_s3 <= r_s2;   // tracks s2 in every state, so stray events are absorbed
      end
   end

   assign w_ev  = r_s2 ^ r_s3;
   assign w_gnt = rr_pick(bus.req, r_ptr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= S_IDLE;
         r_ptr    <= PW'(N - 1);
         r_sq_x   <= '0;
         r_sq_req <= 1'b0;
         r_y      <= '0;
         r_done   <= '0;
         r_err    <= 1'b0;
         r_cnt    <= '0;
         r_drn    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_ptr    <= w_ptr_nxt;
         r_sq_x   <= w_sq_x_nxt;
         r_sq_req <= w_sq_req_nxt;
         r_y      <= w_y_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
         r_cnt    <= w_cnt_nxt;
         r_drn    <= w_drn_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_ptr_nxt    = r_ptr;
      w_sq_x_nxt   = r_sq_x;
      w_sq_req_nxt = r_sq_req;
      w_y_nxt      = r_y;
      w_done_nxt   = '0;
      w_err_nxt    = 1'b0;
      w_cnt_nxt    = r_cnt;
      w_drn_nxt    = r_drn;
      unique case (r_state)
         S_IDLE: begin
            if (|bus.req) begin
               w_ptr_nxt   = w_gnt;
               w_sq_x_nxt  = bus.x[w_gnt*Width +: Width];
               w_state_nxt = S_SETUP;
            end
         end
         // sq_x has been stable for a full cycle before sq_req rises here.
         S_SETUP: begin
            w_sq_req_nxt = 1'b1;
            w_cnt_nxt    = '0;
            w_state_nxt  = S_WAIT;
         end
         // A finish event takes precedence over a timeout in the same cycle.
         S_WAIT: begin
            if (w_ev) begin
               w_y_nxt      = bus.sq_y;
               w_done_nxt   = {{(N-1){1'b0}}, 1'b1} << r_ptr;
               w_sq_req_nxt = 1'b0;
               w_drn_nxt    = 1'b0;
               w_state_nxt  = S_DRAIN;
            end else if (r_cnt == CW'(TimeoutCycles - 1)) begin
               w_err_nxt    = 1'b1;
               w_sq_req_nxt = 1'b0;
               w_drn_nxt    = 1'b0;
               w_state_nxt  = S_DRAIN;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         // Two cycles of guaranteed sq_req low time.
         S_DRAIN: begin
            if (r_drn) w_state_nxt = S_IDLE;
            else       w_drn_nxt   = 1'b1;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign bus.done   = r_done;
   assign bus.y      = r_y;
   assign bus.err    = r_err;
   assign bus.busy   = (r_state != S_IDLE);
   assign bus.sq_req = r_sq_req;
   assign bus.sq_x   = r_sq_x;
endmodule
